// File: rtl/decode_ctrl_seq.sv
// Opcode decoder and issue sequencer: decodes an opcode into a one-hot control
// word plus datapath controls, stalls multi-cycle ops, and holds the word until execute accepts it.
module decode_ctrl_seq #(
  parameter int OPW     = 5,
  parameter int NCTRL   = 20,
  parameter int MUL_CYC = 3,
  parameter int DIV_CYC = 8,
  parameter int FFT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   op_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic             flush_i,
  input  logic             ex_ready_i,
  output logic             ctrl_valid_o,
  output logic [NCTRL-1:0] ctrl_o,
  output logic             branch_o,
  output logic             regwrite_o,
  output logic             memtoreg_o,
  output logic             memwrite_o,
  output logic             alusrc_o,
  output logic             busy_o,
  output logic             illegal_o
);

  localparam int MAX_CYC_MD = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int MAX_CYC    = (MAX_CYC_MD > FFT_CYC) ? MAX_CYC_MD : FFT_CYC;
  localparam int CW         = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [4:0] OP_MUL  = 5'h02;
  localparam logic [4:0] OP_DIV  = 5'h03;
  localparam logic [4:0] OP_JUMP = 5'h0A;
  localparam logic [4:0] OP_RET  = 5'h0E;
  localparam logic [4:0] OP_LD   = 5'h0F;
  localparam logic [4:0] OP_ST   = 5'h10;
  localparam logic [4:0] OP_FFT  = 5'h1D;
  localparam logic [4:0] OP_ENC  = 5'h1E;
  localparam logic [4:0] OP_DENC = 5'h1F;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

  typedef struct packed {
    logic [NCTRL-1:0] vec;
    logic             branch;
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
    logic             alusrc;
  } word_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_cyc;
  word_t         r_out, w_out_nx, r_pend, w_pend_nx, w_dec;
  logic          r_valid, w_valid_nx;
  logic          r_busy, w_busy_nx;
  logic          r_illegal, w_illegal_nx;
  logic          w_legal, w_multi, w_accept;
  logic [4:0]    w_op5;

  // Decoder: ADD..ST occupy opcodes 0x00..0x10 and map to ctrl bits 19 down to 3.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_dec   = '0;
    w_legal = 1'b0;
    w_multi = 1'b0;
    w_cyc   = '0;
    w_op5   = op_i[4:0];
    if ((op_i >> 5) == '0) begin
      if (w_op5 <= OP_ST) begin
        w_legal   = 1'b1;
        w_dec.vec = NCTRL'(1) << (5'd19 - w_op5);
      end else if (w_op5 == OP_FFT) begin
        w_legal   = 1'b1;
        w_dec.vec = NCTRL'(1);
      end else if (w_op5 == OP_ENC) begin
        w_legal   = 1'b1;
        w_dec.vec = NCTRL'(4);
      end else if (w_op5 == OP_DENC) begin
        w_legal   = 1'b1;
        w_dec.vec = NCTRL'(2);
      end
      w_dec.branch   = (w_op5 >= OP_JUMP) && (w_op5 <= OP_RET);
      w_dec.memtoreg = (w_op5 == OP_LD);
      w_dec.alusrc   = (w_op5 == OP_LD);
      w_dec.memwrite = (w_op5 == OP_ST);
      w_dec.regwrite = w_legal && !w_dec.branch && (w_op5 != OP_ST);
      unique case (w_op5)
        OP_MUL:  begin w_multi = 1'b1; w_cyc = CW'(MUL_CYC - 1); end
        OP_DIV:  begin w_multi = 1'b1; w_cyc = CW'(DIV_CYC - 1); end
        OP_FFT:  begin w_multi = 1'b1; w_cyc = CW'(FFT_CYC - 1); end
        default: ;
      endcase
    end
  end

  // Flush blocks acceptance in the same cycle, so a flushed cycle can never launch an op.
  assign op_ready_o = !flush_i &&
                      ((r_state == S_IDLE) || ((r_state == S_OUT) && ex_ready_i));
  assign w_accept   = op_valid_i && op_ready_o;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_pend_nx    = r_pend;
    w_out_nx     = '0;
    w_valid_nx   = 1'b0;
    w_busy_nx    = 1'b0;
    w_illegal_nx = 1'b0;

    if (flush_i) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_WAIT: begin
          if (r_cnt == '0) begin
            w_state_nx = S_OUT;
            w_valid_nx = 1'b1;
            w_out_nx   = r_pend;
          end else begin
            w_cnt_nx  = r_cnt - 1'b1;
            w_busy_nx = 1'b1;
          end
        end
        S_OUT: begin
          if (ex_ready_i) begin
            w_state_nx = S_IDLE;
          end else begin
            w_valid_nx = 1'b1;
            w_out_nx   = r_out;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    // An accept overrides the OUT handshake result, giving bubble-free issue.
    if (w_accept) begin
      if (!w_legal) begin
        w_state_nx   = S_IDLE;
        w_illegal_nx = 1'b1;
      end else if (w_multi) begin
        w_state_nx = S_WAIT;
        w_cnt_nx   = w_cyc;
        w_busy_nx  = 1'b1;
        w_pend_nx  = w_dec;
      end else begin
        w_state_nx = S_OUT;
        w_valid_nx = 1'b1;
        w_out_nx   = w_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_out     <= '0;
      r_pend    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_out     <= w_out_nx;
      r_pend    <= w_pend_nx;
      r_valid   <= w_valid_nx;
      r_busy    <= w_busy_nx;
      r_illegal <= w_illegal_nx;
    end
  end

  assign ctrl_valid_o = r_valid;
  assign ctrl_o       = r_out.vec;
  assign branch_o     = r_out.branch;
  assign regwrite_o   = r_out.regwrite;
  assign memtoreg_o   = r_out.memtoreg;
  assign memwrite_o   = r_out.memwrite;
  assign alusrc_o     = r_out.alusrc;
  assign busy_o       = r_busy;
  assign illegal_o    = r_illegal;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Directed bench for decode_ctrl_seq: hand-computed control words, latencies,
// back-pressure, illegal opcodes, flush and asynchronous reset.
module tb_decode_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  op_i;
  logic        op_valid_i;
  logic        op_ready_o;
  logic        flush_i;
  logic        ex_ready_i;
  logic        ctrl_valid_o;
  logic [19:0] ctrl_o;
  logic        branch_o, regwrite_o, memtoreg_o, memwrite_o, alusrc_o;
  logic        busy_o, illegal_o;
  logic [4:0]  w_dp;

  int n_total = 0;
  int n_bad   = 0;

  decode_ctrl_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_i         (op_i),
    .op_valid_i   (op_valid_i),
    .op_ready_o   (op_ready_o),
    .flush_i      (flush_i),
    .ex_ready_i   (ex_ready_i),
    .ctrl_valid_o (ctrl_valid_o),
    .ctrl_o       (ctrl_o),
    .branch_o     (branch_o),
    .regwrite_o   (regwrite_o),
    .memtoreg_o   (memtoreg_o),
    .memwrite_o   (memwrite_o),
    .alusrc_o     (alusrc_o),
    .busy_o       (busy_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk = ~clk;

  // {branch, regwrite, memtoreg, memwrite, alusrc}
  assign w_dp = {branch_o, regwrite_o, memtoreg_o, memwrite_o, alusrc_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic valid, input logic [19:0] ctrl,
                            input logic [4:0] dp);
    check({tag, ".valid"}, 32'(ctrl_valid_o), 32'(valid));
    check({tag, ".ctrl"},  32'(ctrl_o),       32'(ctrl));
    check({tag, ".dp"},    32'(w_dp),         32'(dp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    op_i       = '0;
    op_valid_i = 1'b0;
    flush_i    = 1'b0;
    ex_ready_i = 1'b1;

    #3;
    check_word("reset", 1'b0, 20'h0, 5'b00000);
    check("reset.ready",   32'(op_ready_o), 32'd1);
    check("reset.busy",    32'(busy_o),     32'd0);
    check("reset.illegal", 32'(illegal_o),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ADD, single cycle, taken immediately
    op_i = 5'h00; op_valid_i = 1'b1;
    #1 check("add.ready", 32'(op_ready_o), 32'd1);
    tick();
    op_valid_i = 1'b0;
    check_word("add", 1'b1, 20'h80000, 5'b01000);
    tick();
    check_word("add.after", 1'b0, 20'h0, 5'b00000);

    // DIV: eight busy cycles, then one valid cycle
    op_i = 5'h03; op_valid_i = 1'b1;
    tick();
    op_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("div.busy%0d", i),  32'(busy_o),       32'd1);
      check($sformatf("div.valid%0d", i), 32'(ctrl_valid_o), 32'd0);
      tick();
    end
    check("div.busy_end", 32'(busy_o), 32'd0);
    check_word("div", 1'b1, 20'h10000, 5'b01000);
    tick();
    check_word("div.after", 1'b0, 20'h0, 5'b00000);

    // LD held by back-pressure, BEQ waiting behind it
    op_i = 5'h0F; op_valid_i = 1'b1; ex_ready_i = 1'b0;
    tick();
    op_i = 5'h0B;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_word($sformatf("ld.hold%0d", i), 1'b1, 20'h00010, 5'b01101);
      check($sformatf("ld.ready%0d", i), 32'(op_ready_o), 32'd0);
      tick();
    end
    ex_ready_i = 1'b1;
    #1 check("ld.handshake_ready", 32'(op_ready_o), 32'd1);
    tick();
    op_valid_i = 1'b0;
    check_word("beq", 1'b1, 20'h00100, 5'b10000);
    tick();
    check_word("beq.after", 1'b0, 20'h0, 5'b00000);

    // Back-to-back ADD -> ST -> ENC with no bubble
    op_i = 5'h00; op_valid_i = 1'b1;
    tick();
    check_word("b2b.add", 1'b1, 20'h80000, 5'b01000);
    op_i = 5'h10;
    tick();
    check_word("b2b.st", 1'b1, 20'h00008, 5'b00010);
    op_i = 5'h1E;
    tick();
    op_valid_i = 1'b0;
    check_word("b2b.enc", 1'b1, 20'h00004, 5'b01000);
    tick();
    check_word("b2b.after", 1'b0, 20'h0, 5'b00000);

    // Illegal opcodes 0x15 and 0x11
    op_i = 5'h15; op_valid_i = 1'b1;
    tick();
    op_valid_i = 1'b0;
    check("ill15.pulse", 32'(illegal_o),    32'd1);
    check("ill15.valid", 32'(ctrl_valid_o), 32'd0);
    check("ill15.ready", 32'(op_ready_o),   32'd1);
    tick();
    check("ill15.end",   32'(illegal_o),    32'd0);
    check("ill15.valid2", 32'(ctrl_valid_o), 32'd0);
    op_i = 5'h11; op_valid_i = 1'b1;
    tick();
    op_valid_i = 1'b0;
    check("ill11.pulse", 32'(illegal_o), 32'd1);
    tick();

    // FFT flushed on its fifth wait cycle, then ADD issues normally
    op_i = 5'h1D; op_valid_i = 1'b1;
    tick();
    op_valid_i = 1'b0;
    repeat (4) tick();
    check("fft.busy_w5", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    #1 check("fft.flush_ready", 32'(op_ready_o), 32'd0);
    tick();
    flush_i = 1'b0;
    check("fft.busy_flushed", 32'(busy_o), 32'd0);
    check_word("fft.flushed", 1'b0, 20'h0, 5'b00000);
    op_i = 5'h00; op_valid_i = 1'b1;
    tick();
    op_valid_i = 1'b0;
    check_word("fft.add", 1'b1, 20'h80000, 5'b01000);
    tick();

    // Flush in IDLE blocks an offered op
    op_i = 5'h00; op_valid_i = 1'b1; flush_i = 1'b1;
    #1 check("flush.ready", 32'(op_ready_o), 32'd0);
    tick();
    op_valid_i = 1'b0; flush_i = 1'b0;
    check_word("flush.none", 1'b0, 20'h0, 5'b00000);
    tick();

    // Reset during MUL wait discards the op
    op_i = 5'h02; op_valid_i = 1'b1;
    tick();
    op_valid_i = 1'b0;
    check("mul.busy", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mulrst.busy",  32'(busy_o),     32'd0);
    check("mulrst.ready", 32'(op_ready_o), 32'd1);
    check_word("mulrst", 1'b0, 20'h0, 5'b00000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("mulrst.post%0d", i), 32'({ctrl_valid_o, busy_o, illegal_o}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
